// File: rtl/multichan_delay_capture.sv
// Multi-channel 1-bit sample delay line with trigger capture and frozen history readout.
// The capture-release pulse is named release_req because "release" is a reserved word.
module multichan_delay_capture #(
    parameter int unsigned NUM_CH       = 7,
    parameter int unsigned DEPTH        = 80,
    parameter int unsigned POST_SAMPLES = 40,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [NUM_CH-1:0] din,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_ch,
    input  logic [AW-1:0]     cfg_dly,
    input  logic              arm,
    input  logic              trig,
    input  logic              release_req,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] dout_vld,
    output logic [NUM_CH-1:0] rd_data,
    output logic              rd_valid,
    output logic              frozen
);

    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {RUN, ARMED, POST, FROZEN} state_t;

    state_t           state;
    logic [AW-1:0]    post_cnt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_next;
    logic [DEPTH-1:0] hist [NUM_CH];
    logic [AW-1:0]    dly  [NUM_CH];
    logic             shift;

    assign shift     = sample_en && (state != FROZEN);
    assign fill_next = (32'(fill) >= DEPTH) ? fill : fill + FW'(1);

    // Capture state machine; release wins over arm, arm over trig.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            post_cnt <= '0;
            frozen   <= 1'b0;
        end else begin
            frozen <= (state == FROZEN);
            case (state)
                RUN: begin
                    if (arm && !release_req) state <= ARMED;
                end
                ARMED: begin
                    if (release_req) begin
                        state <= RUN;
                    end else if (trig) begin
                        post_cnt <= '0;
                        state    <= (POST_SAMPLES == 0) ? FROZEN : POST;
                    end
                end
                POST: begin
                    if (release_req) begin
                        state <= RUN;
                    end else if (shift) begin
                        if (32'(post_cnt) + 32'd1 == POST_SAMPLES) state <= FROZEN;
                        else post_cnt <= post_cnt + AW'(1);
                    end
                end
                FROZEN: begin
                    if (release_req) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // History shift, delayed tap and per-channel validity on every shifting strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) hist[c] <= '0;
            dout     <= '0;
            dout_vld <= '0;
            fill     <= '0;
        end else if (shift) begin
            fill <= fill_next;
            for (int c = 0; c < NUM_CH; c++) begin
                hist[c]     <= {hist[c][DEPTH-2:0], din[c]};
                dout[c]     <= hist[c][dly[c]];
                dout_vld[c] <= (32'(fill_next) > 32'(dly[c]));
            end
        end
    end

    // Per-channel delay configuration; out-of-range delays clamp to the oldest tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) dly[c] <= '0;
        end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
            dly[cfg_ch[CW-1:0]] <= (32'(cfg_dly) >= DEPTH) ? AW'(DEPTH - 1) : cfg_dly;
        end
    end

    // Random-access readout of the frozen history; addresses past the end read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_en && (state == FROZEN)) begin
                rd_valid <= 1'b1;
                for (int c = 0; c < NUM_CH; c++)
                    rd_data[c] <= (32'(rd_addr) < DEPTH) ? hist[c][rd_addr] : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multichan_delay_capture.sv
// Scoreboard bench for multichan_delay_capture against a sample-log reference model.
module tb_multichan_delay_capture;

    localparam int NUM_CH = 7;
    localparam int DEPTH  = 80;
    localparam int POST   = 40;
    localparam int AW     = 7;

    localparam int M_RUN    = 0;
    localparam int M_ARMED  = 1;
    localparam int M_POST   = 2;
    localparam int M_FROZEN = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_en;
    logic [NUM_CH-1:0] din;
    logic              cfg_we;
    logic [7:0]        cfg_ch;
    logic [AW-1:0]     cfg_dly;
    logic              arm;
    logic              trig;
    logic              release_req;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [NUM_CH-1:0] dout;
    logic [NUM_CH-1:0] dout_vld;
    logic [NUM_CH-1:0] rd_data;
    logic              rd_valid;
    logic              frozen;

    multichan_delay_capture dut (
        .clk         (clk),
        .reset       (reset),
        .sample_en   (sample_en),
        .din         (din),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_dly     (cfg_dly),
        .arm         (arm),
        .trig        (trig),
        .release_req (release_req),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .frozen      (frozen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [NUM_CH-1:0] dout;
        logic [NUM_CH-1:0] vld;
        logic              frz;
    } exp_t;

    typedef struct {
        int                due;
        logic [NUM_CH-1:0] data;
    } rexp_t;

    exp_t  eq[$];
    rexp_t rq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: every accepted sample in arrival order, plus capture state.
    logic [NUM_CH-1:0] log_q[$];
    int                m_dly [NUM_CH];
    int                m_state;
    int                m_pc;
    logic [NUM_CH-1:0] m_dout;
    logic [NUM_CH-1:0] m_vld;
    logic              m_frz;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Value stored a given number of samples back (0 = newest); unfilled or out-of-range reads 0.
    function automatic logic [NUM_CH-1:0] hist_at(input int a);
        int n;
        n = log_q.size();
        if (a < DEPTH && a < n) return log_q[n - 1 - a];
        return '0;
    endfunction

    task automatic clear_pulses();
        reset       = 1'b0;
        cfg_we      = 1'b0;
        cfg_ch      = 8'd0;
        cfg_dly     = '0;
        arm         = 1'b0;
        trig        = 1'b0;
        release_req = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
    endtask

    // Advance the model by one clock with the currently driven inputs and queue expectations.
    task automatic tick();
        exp_t              e;
        rexp_t             r;
        int                old;
        int                n;
        int                fill;
        bit                sh;
        logic [NUM_CH-1:0] tmp;
        if (reset) begin
            log_q.delete();
            for (int c = 0; c < NUM_CH; c++) m_dly[c] = 0;
            m_state = M_RUN;
            m_pc    = 0;
            m_dout  = '0;
            m_vld   = '0;
            m_frz   = 1'b0;
        end else begin
            old   = m_state;
            sh    = sample_en && (old != M_FROZEN);
            m_frz = (old == M_FROZEN);
            if (rd_en && old == M_FROZEN) begin
                r.due  = cyc + 1;
                r.data = hist_at(int'(rd_addr));
                rq.push_back(r);
            end
            if (sh) begin
                n    = log_q.size();
                fill = (n + 1 > DEPTH) ? DEPTH : n + 1;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (n > m_dly[c]) begin
                        tmp       = log_q[n - 1 - m_dly[c]];
                        m_dout[c] = tmp[c];
                    end else begin
                        m_dout[c] = 1'b0;
                    end
                    m_vld[c] = (fill > m_dly[c]);
                end
                log_q.push_back(din);
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH)
                m_dly[int'(cfg_ch)] = (int'(cfg_dly) >= DEPTH) ? DEPTH - 1 : int'(cfg_dly);
            if (release_req) begin
                m_state = M_RUN;
            end else begin
                case (old)
                    M_RUN:   if (arm) m_state = M_ARMED;
                    M_ARMED: if (trig) begin
                        m_pc    = 0;
                        m_state = (POST == 0) ? M_FROZEN : M_POST;
                    end
                    M_POST:  if (sh) begin
                        m_pc++;
                        if (m_pc == POST) m_state = M_FROZEN;
                    end
                    default: ;
                endcase
            end
        end
        e.due  = cyc + 1;
        e.dout = m_dout;
        e.vld  = m_vld;
        e.frz  = m_frz;
        eq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compares queued expectations against the DUT away from the active edge.
    exp_t  mon_e;
    rexp_t mon_r;
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].due <= cyc) begin
            mon_e = eq.pop_front();
            if (mon_e.due == cyc) begin
                check("dout", 32'(dout), 32'(mon_e.dout));
                check("dout_vld", 32'(dout_vld), 32'(mon_e.vld));
                check("frozen", 32'(frozen), 32'(mon_e.frz));
            end
        end
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                mon_r = rq.pop_front();
                check("rd_latency", 32'(cyc), 32'(mon_r.due));
                check("rd_data", 32'(rd_data), 32'(mon_r.data));
            end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            mon_r = rq.pop_front();
            check("rd_valid_missing", 32'(rd_valid), 32'd1);
        end
    end

    task automatic do_reset(input int cycles);
        clear_pulses();
        reset     = 1'b1;
        sample_en = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input int ch, input int d);
        clear_pulses();
        cfg_we    = 1'b1;
        cfg_ch    = 8'(ch);
        cfg_dly   = AW'(d);
        sample_en = 1'($urandom_range(0, 1));
        din       = NUM_CH'($urandom);
        tick();
        clear_pulses();
    endtask

    // Strobe randomly until the model reports the given capture state, bounded.
    task automatic run_until(input int st, input int budget);
        int k;
        k = 0;
        while (m_state != st && k < budget) begin
            sample_en = 1'($urandom_range(0, 1));
            din       = NUM_CH'($urandom);
            tick();
            k++;
        end
        check("capture_state_reached", 32'(m_state), 32'(st));
    endtask

    int addrs[8] = '{0, 40, 79, 80, 127, 1, 39, 41};
    int strobes;
    int cnt;

    initial begin
        clear_pulses();
        reset     = 1'b1;
        sample_en = 1'b0;
        din       = '0;
        @(negedge clk);
        do_reset(2);

        // Zero delays, strobe every cycle, walking one on channel 0.
        for (int i = 0; i < 30; i++) begin
            sample_en = 1'b1;
            din       = {NUM_CH'($urandom) >> 1, 1'((i % 5) == 0)};
            rd_en     = 1'($urandom_range(0, 1));
            rd_addr   = AW'($urandom);
            tick();
            clear_pulses();
        end

        // Delay programming, including clamp and out-of-range channel.
        do_reset(1);
        cfg(3, 5);
        cfg(1, 127);
        cfg(9, 3);
        cfg(6, 79);
        cfg(0, $urandom_range(0, 10));
        cfg(200, 12);
        for (int i = 0; i < 200; i++) begin
            sample_en = 1'((i % 3) == 0);
            din       = NUM_CH'($urandom);
            trig      = ($urandom_range(0, 19) == 0);
            tick();
            clear_pulses();
        end

        // Capture: arm+trig together only arms; trig on the 60th strobe of a counter pattern.
        arm       = 1'b1;
        trig      = 1'b1;
        sample_en = 1'b0;
        tick();
        clear_pulses();
        strobes = 0;
        cnt     = 0;
        while (strobes < 60) begin
            sample_en = 1'($urandom_range(0, 1));
            din       = NUM_CH'(cnt);
            if (sample_en) begin
                strobes++;
                cnt++;
                trig = (strobes == 60);
            end
            tick();
            clear_pulses();
        end
        for (int i = 0; i < 200 && m_state != M_FROZEN; i++) begin
            sample_en = 1'($urandom_range(0, 1));
            din       = NUM_CH'(cnt);
            if (sample_en) cnt++;
            tick();
        end
        check("post_frozen", 32'(m_state), 32'(M_FROZEN));
        clear_pulses();

        // Frozen: strobes ignored, readout of assorted addresses.
        for (int i = 0; i < 20; i++) begin
            sample_en = 1'b1;
            din       = NUM_CH'($urandom);
            rd_en     = 1'b1;
            rd_addr   = (i < 8) ? AW'(addrs[i]) : AW'($urandom);
            tick();
        end
        clear_pulses();
        release_req = 1'b1;
        sample_en   = 1'b0;
        tick();
        clear_pulses();
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1;
            din       = NUM_CH'($urandom);
            rd_en     = 1'($urandom_range(0, 1));
            tick();
        end
        clear_pulses();

        // Abort in POST via release, with arm asserted too.
        arm = 1'b1;
        tick();
        clear_pulses();
        trig = 1'b1;
        tick();
        clear_pulses();
        for (int i = 0; i < 8; i++) begin
            sample_en = 1'b1;
            din       = NUM_CH'($urandom);
            tick();
        end
        release_req = 1'b1;
        arm         = 1'b1;
        tick();
        clear_pulses();
        for (int i = 0; i < 60; i++) begin
            sample_en = 1'($urandom_range(0, 1));
            din       = NUM_CH'($urandom);
            trig      = 1'($urandom_range(0, 1));
            tick();
            clear_pulses();
        end

        // Second full capture with random strobes, then readout of every address.
        arm = 1'b1;
        tick();
        clear_pulses();
        trig = 1'b1;
        run_until(M_FROZEN, 2000);
        clear_pulses();
        for (int a = 0; a < DEPTH + 2; a++) begin
            rd_en     = 1'b1;
            rd_addr   = AW'(a);
            sample_en = 1'($urandom_range(0, 1));
            tick();
        end
        clear_pulses();
        release_req = 1'b1;
        tick();
        clear_pulses();

        // Reset during POST discards state and delays.
        cfg(2, 4);
        arm = 1'b1;
        tick();
        clear_pulses();
        trig = 1'b1;
        tick();
        clear_pulses();
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1;
            din       = NUM_CH'($urandom);
            tick();
        end
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            sample_en = 1'b1;
            din       = NUM_CH'($urandom);
            tick();
        end
        clear_pulses();
        sample_en = 1'b0;
        tick();
        tick();

        check("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
